// File: rtl/dmem_arbiter.sv
// Arbiter that shares one single-port data memory between the core and a loader.
// Grants are combinational; read data returns one cycle after acceptance.
module dmem_arbiter #(
  parameter int unsigned LD_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        core_req,
  input  logic        core_wren,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,

  input  logic        ld_req,
  input  logic        ld_wren,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_gnt,
  output logic        ld_rvalid,
  output logic [31:0] ld_rdata,

  output logic        mem_en,
  output logic        mem_wren,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_LD   = 1'b1
  } owner_t;

  localparam logic [3:0] BURST_MAX = 4'(LD_BURST_MAX);

  owner_t     last_grant, last_grant_nxt;
  logic [3:0] burst_cnt,  burst_cnt_nxt;
  logic [1:0] rd_owner,   rd_owner_nxt;   // {core pending, loader pending}

  // Grant selection. A non-zero burst_cnt marks an ongoing loader burst, so the
  // override only applies once the loader has actually won a contended cycle.
  always_comb begin
    core_gnt = 1'b0;
    ld_gnt   = 1'b0;
    if (!reset) begin
      if (core_req && ld_req) begin
        if (last_grant == OWNER_CORE) begin
          ld_gnt = 1'b1;
        end else if (burst_cnt != '0 && burst_cnt < BURST_MAX) begin
          ld_gnt = 1'b1;
        end else begin
          core_gnt = 1'b1;
        end
      end else begin
        core_gnt = core_req;
        ld_gnt   = ld_req;
      end
    end
  end

  always_comb begin
    mem_en    = core_gnt | ld_gnt;
    mem_wren  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_wren  = core_wren;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (ld_gnt) begin
      mem_wren  = ld_wren;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end
  end

  always_comb begin
    last_grant_nxt = last_grant;
    if (core_gnt) begin
      last_grant_nxt = OWNER_CORE;
    end else if (ld_gnt) begin
      last_grant_nxt = OWNER_LD;
    end

    burst_cnt_nxt = burst_cnt;
    if (!ld_req || core_gnt) begin
      burst_cnt_nxt = '0;
    end else if (ld_gnt && core_req && burst_cnt < BURST_MAX) begin
      burst_cnt_nxt = burst_cnt + 4'd1;
    end

    rd_owner_nxt = {core_gnt & ~core_wren, ld_gnt & ~ld_wren};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= OWNER_LD;
      burst_cnt  <= '0;
      rd_owner   <= '0;
    end else begin
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
      rd_owner   <= rd_owner_nxt;
    end
  end

  always_comb begin
    core_rvalid = rd_owner[1];
    ld_rvalid   = rd_owner[0];
    core_rdata  = core_rvalid ? mem_rdata : '0;
    ld_rdata    = ld_rvalid   ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural memory model.
// Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        core_req, core_wren, ld_req, ld_wren;
  logic [31:0] core_addr, core_wdata, ld_addr, ld_wdata;
  logic        core_gnt, core_rvalid, ld_gnt, ld_rvalid;
  logic [31:0] core_rdata, ld_rdata;
  logic        mem_en, mem_wren;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] mem [logic [31:0]];

  dmem_arbiter #(.LD_BURST_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_wren(core_wren), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .ld_req(ld_req), .ld_wren(ld_wren), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: unwritten words read back as the inverted address.
  always @(posedge clk) begin
    if (mem_en && mem_wren) begin
      mem[mem_addr] = mem_wdata;
    end
    if (mem_en && !mem_wren) begin
      mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : ~mem_addr;
    end else begin
      mem_rdata <= 32'hBAD0_BAD0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input logic creq, input logic cwr, input logic [31:0] caddr,
                       input logic [31:0] cwd, input logic lreq, input logic lwr,
                       input logic [31:0] laddr, input logic [31:0] lwd);
    core_req = creq; core_wren = cwr; core_addr = caddr; core_wdata = cwd;
    ld_req   = lreq; ld_wren   = lwr; ld_addr   = laddr; ld_wdata   = lwd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 32'h1234, 32'h5678, 1'b1, 1'b1, 32'h9ABC, 32'hDEF0);
    @(negedge clk);
    checks++;
    if ({core_gnt, ld_gnt, mem_en, mem_wren, core_rvalid, ld_rvalid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {core_gnt, ld_gnt, mem_en, mem_wren, core_rvalid, ld_rvalid});
    end
    checks++;
    if ({mem_addr, mem_wdata, core_rdata, ld_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h expected all 0",
               mem_addr, mem_wdata, core_rdata, ld_rdata);
    end
    checks++;
    if ({1'(dut.last_grant), dut.burst_cnt, dut.rd_owner} !== 7'b1_0000_00) begin
      errors++;
      $display("FAIL reset_state: got last=%b burst=%0d owner=%b expected 1 0 00",
               dut.last_grant, dut.burst_cnt, dut.rd_owner);
    end
    next_cycle();
    reset = 1'b0;
    idle();
  endtask

  task automatic test_core_read();
    drive(1'b1, 1'b0, 32'h100, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if ({core_gnt, ld_gnt, mem_en, mem_wren, core_rvalid} !== 5'b10100) begin
      errors++;
      $display("FAIL core_rd_gnt: got %b expected 10100",
               {core_gnt, ld_gnt, mem_en, mem_wren, core_rvalid});
    end
    checks++;
    if (mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL core_rd_addr: got %h expected 00000100", mem_addr);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if ({core_rvalid, ld_rvalid, core_gnt, mem_en} !== 4'b1000) begin
      errors++;
      $display("FAIL core_rd_valid: got %b expected 1000",
               {core_rvalid, ld_rvalid, core_gnt, mem_en});
    end
    checks++;
    if (core_rdata !== 32'hDEADBEEF || ld_rdata !== 32'h0) begin
      errors++;
      $display("FAIL core_rd_data: got core=%h ld=%h expected deadbeef 00000000",
               core_rdata, ld_rdata);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    logic [7:0] exp_core;
    exp_core = 8'b0010_0001;  // bit i set: core wins cycle i
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 32'h300 + 32'(4 * i), '0, 1'b1, 1'b0, 32'h400 + 32'(4 * i), '0);
      @(negedge clk);
      checks++;
      if ({core_gnt, ld_gnt} !== {exp_core[i], ~exp_core[i]}) begin
        errors++;
        $display("FAIL contention_%0d: got core=%b ld=%b expected core=%b ld=%b",
                 i, core_gnt, ld_gnt, exp_core[i], ~exp_core[i]);
      end
      checks++;
      if (mem_addr !== (exp_core[i] ? 32'h300 + 32'(4 * i) : 32'h400 + 32'(4 * i))) begin
        errors++;
        $display("FAIL contention_addr_%0d: got %h", i, mem_addr);
      end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_burst_clear();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h10, '0, 1'b1, 1'b0, 32'h20, '0);
      @(negedge clk);
      checks++;
      if ({core_gnt, ld_gnt} !== ((i == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL burst_pre_%0d: got %b expected %b", i, {core_gnt, ld_gnt},
                 (i == 0) ? 2'b10 : 2'b01);
      end
      next_cycle();
    end
    idle();
    next_cycle();
    drive(1'b1, 1'b0, 32'h10, '0, 1'b1, 1'b0, 32'h20, '0);
    @(negedge clk);
    checks++;
    if ({core_gnt, ld_gnt, dut.burst_cnt} !== 6'b10_0000) begin
      errors++;
      $display("FAIL burst_clear: got gnt=%b burst=%0d expected gnt=10 burst=0",
               {core_gnt, ld_gnt}, dut.burst_cnt);
    end
    next_cycle();
    idle();
    next_cycle();
  endtask

  task automatic test_loader_write();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'(4 * i), 32'hA000_0000 + 32'(i));
      @(negedge clk);
      checks++;
      if ({core_gnt, ld_gnt, mem_en, mem_wren, core_rvalid, ld_rvalid} !== 6'b011100) begin
        errors++;
        $display("FAIL ld_wr_ctrl_%0d: got %b expected 011100", i,
                 {core_gnt, ld_gnt, mem_en, mem_wren, core_rvalid, ld_rvalid});
      end
      checks++;
      if (mem_addr !== 32'(4 * i) || mem_wdata !== 32'hA000_0000 + 32'(i)) begin
        errors++;
        $display("FAIL ld_wr_data_%0d: got addr=%h data=%h", i, mem_addr, mem_wdata);
      end
      next_cycle();
    end
    idle();
    @(negedge clk);
    checks++;
    if ({core_rvalid, ld_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL ld_wr_norvalid: got %b expected 00", {core_rvalid, ld_rvalid});
    end
    next_cycle();
  endtask

  task automatic test_alternating();
    logic [31:0] prev_addr;
    logic        prev_core;
    prev_addr = '0;
    prev_core = 1'b0;
    for (int i = 0; i < 7; i++) begin
      logic        is_core;
      logic [31:0] addr;
      is_core = (i % 2 == 0);
      addr    = is_core ? 32'h500 + 32'(4 * i) : 32'h600 + 32'(4 * i);
      if (i == 6) idle();
      else if (is_core) drive(1'b1, 1'b0, addr, '0, 1'b0, 1'b0, '0, '0);
      else drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, addr, '0);
      @(negedge clk);
      if (i < 6) begin
        checks++;
        if ({core_gnt, ld_gnt} !== {is_core, ~is_core}) begin
          errors++;
          $display("FAIL alt_gnt_%0d: got %b expected %b", i, {core_gnt, ld_gnt},
                   {is_core, ~is_core});
        end
      end
      if (i > 0) begin
        checks++;
        if ({core_rvalid, ld_rvalid} !== {prev_core, ~prev_core}) begin
          errors++;
          $display("FAIL alt_rvalid_%0d: got %b expected %b", i,
                   {core_rvalid, ld_rvalid}, {prev_core, ~prev_core});
        end
        checks++;
        if ((prev_core ? core_rdata : ld_rdata) !== ~prev_addr ||
            (prev_core ? ld_rdata : core_rdata) !== 32'h0) begin
          errors++;
          $display("FAIL alt_rdata_%0d: got core=%h ld=%h expected %h on %s", i,
                   core_rdata, ld_rdata, ~prev_addr, prev_core ? "core" : "ld");
        end
      end
      prev_addr = addr;
      prev_core = is_core;
      next_cycle();
    end
  endtask

  task automatic test_read_then_write();
    drive(1'b1, 1'b0, 32'h4, '0, 1'b0, 1'b0, '0, '0);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h700, 32'h1234_5678);
    @(negedge clk);
    checks++;
    if ({ld_gnt, mem_wren, core_rvalid, ld_rvalid} !== 4'b1110) begin
      errors++;
      $display("FAIL rw_ctrl: got %b expected 1110", {ld_gnt, mem_wren, core_rvalid, ld_rvalid});
    end
    checks++;
    if (core_rdata !== 32'hA000_0001 || mem_addr !== 32'h700 || mem_wdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rw_data: got rdata=%h addr=%h wdata=%h expected a0000001 00000700 12345678",
               core_rdata, mem_addr, mem_wdata);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if ({core_rvalid, ld_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL rw_after: got %b expected 00", {core_rvalid, ld_rvalid});
    end
    next_cycle();
  endtask

  task automatic test_reset_inflight();
    drive(1'b1, 1'b0, 32'h800, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (core_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rst_inflight_gnt: got %b expected 1", core_gnt);
    end
    next_cycle();
    reset = 1'b1;
    idle();
    #1;
    checks++;
    if ({core_rvalid, core_rdata} !== 33'h0) begin
      errors++;
      $display("FAIL rst_inflight_during: got rvalid=%b rdata=%h expected 0 0",
               core_rvalid, core_rdata);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({core_rvalid, ld_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL rst_inflight_after: got %b expected 00", {core_rvalid, ld_rvalid});
    end
    next_cycle();
    drive(1'b1, 1'b0, 32'h10, '0, 1'b1, 1'b0, 32'h20, '0);
    @(negedge clk);
    checks++;
    if ({core_gnt, ld_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL rst_inflight_first: got %b expected 10", {core_gnt, ld_gnt});
    end
    next_cycle();
    idle();
    next_cycle();
  endtask

  task automatic test_idle();
    idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({core_gnt, ld_gnt, mem_en, mem_wren, core_rvalid, ld_rvalid, dut.burst_cnt} !== 10'h0 ||
          {mem_addr, mem_wdata, core_rdata, ld_rdata} !== 128'h0) begin
        errors++;
        $display("FAIL idle_%0d: got ctrl=%b burst=%0d addr=%h wdata=%h expected all 0", i,
                 {core_gnt, ld_gnt, mem_en, mem_wren, core_rvalid, ld_rvalid},
                 dut.burst_cnt, mem_addr, mem_wdata);
      end
      next_cycle();
    end
  endtask

  initial begin
    mem[32'h100] = 32'hDEADBEEF;
    reset = 1'b1;
    idle();
    test_reset();
    test_core_read();
    test_contention();
    test_burst_clear();
    test_loader_write();
    test_alternating();
    test_read_then_write();
    test_reset_inflight();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: LD_BURST_MAX, default 4, max consecutive loader grants while core is also requesting (range 1..15).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 core_req / core_wren  in  1/1  core access request / write (1) vs read (0).
REQ-006 core_addr / core_wdata  in  32/32  core byte address / write data.
REQ-007 core_gnt  out  1  core access accepted this cycle (low = core stalls PC).
REQ-008 core_rvalid / core_rdata  out  1/32  core read data valid / data.
REQ-009 ld_req / ld_wren  in  1/1  loader (DMA/program-load) request / write.
REQ-010 ld_addr / ld_wdata  in  32/32  loader address / write data.
REQ-011 ld_gnt  out  1  loader access accepted this cycle.
REQ-012 ld_rvalid / ld_rdata  out  1/32  loader read data valid / data.
REQ-013 mem_en / mem_wren  out  1/1  memory port access / write.
REQ-014 mem_addr / mem_wdata  out  32/32  memory address / write data.
REQ-015 mem_rdata  in  32  memory read data, valid exactly 1 cycle after a read access.

Function
REQ-016 Sharing of one single-port data memory between core and loader; at most one grant per cycle.
REQ-017 Grant combinational, same cycle as req; a request is accepted on a rising edge with req=1 and gnt=1; no queueing.
REQ-018 Only one requester active -> that requester granted.
REQ-019 Both requesting -> round-robin: grant goes to the requester NOT recorded in last_grant register.
REQ-020 Override: loader granted this cycle and burst_cnt < LD_BURST_MAX -> loader keeps grant while both request.
REQ-021 burst_cnt (4 bits): +1 on each loader grant while core_req=1; cleared on any core grant or any cycle ld_req=0; saturates at LD_BURST_MAX.
REQ-022 burst_cnt = LD_BURST_MAX with both requesting -> core granted next, regardless of override.
REQ-023 last_grant updated only on cycles where a grant occurs; held otherwise.
REQ-024 mem_en = core_gnt | ld_gnt; mem_wren/addr/wdata = granted requester's fields; all zero when no grant.
REQ-025 Read accepted at cycle N -> requester's rvalid=1 at cycle N+1 with rdata = mem_rdata; other rvalid=0.
REQ-026 rd_owner register (2 bits: core-pending, ld-pending) records owner of the read in flight; writes produce no rvalid.
REQ-027 rdata outputs driven with mem_rdata only when matching rvalid=1; zero otherwise.
REQ-028 Back-to-back reads from either/alternating requesters sustained at 1 access/cycle, no bubbles.
REQ-029 Read then write at N, N+1: rvalid for the read still asserted at N+1 concurrent with write access.
REQ-030 No requests -> all outputs zero, state (except burst_cnt cleared) held.

Reset
REQ-031 Reset asserted -> last_grant = loader (core wins first contention), burst_cnt = 0, rd_owner = 0, immediately (asynchronous).
REQ-032 During reset: core_gnt, ld_gnt, mem_en, mem_wren, both rvalid = 0; all data/address outputs = 0.
REQ-033 Reset during a read in flight: that read's rvalid never asserted after reset release.
REQ-034 First grant possible on the first rising edge after reset deasserts.

Verification
REQ-035 Core-only read addr 0x100, mem_rdata=0xDEADBEEF next cycle -> core_gnt=1 at N, core_rvalid=1 with core_rdata=0xDEADBEEF at N+1, ld_rvalid=0.
REQ-036 Both requesting reads after reset, LD_BURST_MAX=4 -> grant sequence core, ld, ld, ld, ld, core, ld...
REQ-037 Loader writes 0x0..0xC (4 beats), core idle -> ld_gnt every cycle, mem_wren=1, mem_addr=ld_addr, no rvalid.
REQ-038 Alternating core read / loader read every cycle -> rvalid routed to correct requester each cycle, rdata matches memory model.
REQ-039 Reset pulse one cycle after core read grant -> core_rvalid stays 0; post-reset contention grants core first.
REQ-040 Idle 10 cycles -> mem_en=0, all gnt/rvalid 0, burst_cnt=0.
